// File: rtl/ahb_slave_select_ctrl.sv
// Address decoder and data-phase response sequencer for a three-slave AHB segment.
// It also contains the default slave, which returns a two-cycle ERROR, and a stall watchdog.
module ahb_slave_select_ctrl #(
  parameter logic [31:0] S1_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_MASK = 32'hF000_0000,
  parameter logic [31:0] S2_BASE = 32'h1000_0000,
  parameter logic [31:0] S2_MASK = 32'hF000_0000,
  parameter logic [31:0] S3_BASE = 32'h2000_0000,
  parameter logic [31:0] S3_MASK = 32'hF000_0000,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY_1,
  input  logic        HREADY_2,
  input  logic        HREADY_3,
  output logic        HSEL_1,
  output logic        HSEL_2,
  output logic        HSEL_3,
  output logic [1:0]  SEL,
  output logic        HREADY,
  output logic [1:0]  HRESP_DEF,
  output logic        TIMEOUT_P
);

  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StErr1 = 2'd1;
  localparam logic [1:0] StErr2 = 2'd2;

  localparam logic [1:0] SelDef = 2'b11;

  logic            hit_1, hit_2, hit_3;
  logic [1:0]      dec_idx;
  logic            dec_def;
  logic            xfer_req;
  logic [1:0]      sel_q;
  logic [1:0]      state_q, state_d;
  logic            hready_def;
  logic            wait_cyc;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            unused_htrans;

  // HTRANS[0] (SEQ vs NONSEQ, BUSY vs IDLE) does not change how the decoder responds.
  assign unused_htrans = HTRANS[0];

  assign hit_1 = (HADDR & S1_MASK) == S1_BASE;
  assign hit_2 = (HADDR & S2_MASK) == S2_BASE;
  assign hit_3 = (HADDR & S3_MASK) == S3_BASE;

  always_comb begin
    HSEL_1 = hit_1;
    HSEL_2 = !hit_1 && hit_2;
    HSEL_3 = !hit_1 && !hit_2 && hit_3;
    if (HSEL_1) begin
      dec_idx = 2'b00;
    end else if (HSEL_2) begin
      dec_idx = 2'b01;
    end else if (HSEL_3) begin
      dec_idx = 2'b10;
    end else begin
      dec_idx = SelDef;
    end
  end

  assign dec_def  = (dec_idx == SelDef);
  assign xfer_req = dec_def && HTRANS[1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sel_q <= SelDef;
    end else if (HREADY) begin
      sel_q <= dec_idx;
    end
  end

  assign SEL = sel_q;

  always_comb begin
    case (sel_q)
      2'b00:   HREADY = HREADY_1;
      2'b01:   HREADY = HREADY_2;
      2'b10:   HREADY = HREADY_3;
      default: HREADY = hready_def;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (HREADY && xfer_req) state_d = StErr1;
      StErr1:  state_d = StErr2;
      StErr2:  state_d = xfer_req ? StErr1 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign hready_def = (state_q != StErr1);
  assign HRESP_DEF  = ((sel_q == SelDef) && (state_q != StIdle)) ? 2'b01 : 2'b00;

  // Watchdog only observes slave stalls; the default slave's own wait cycle is excluded.
  assign wait_cyc = !HREADY && (sel_q != SelDef);

  always_comb begin
    cnt_d = cnt_q;
    if (HREADY) begin
      cnt_d = '0;
    end else if (wait_cyc && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Pulse during the TIMEOUT-th consecutive wait cycle, which is when the count reaches TIMEOUT.
  assign TIMEOUT_P = wait_cyc && (cnt_q == (CntMax - CntW'(1)));

endmodule
